sign_flag_checker: RTL and testbench
====================================

// Module: sign_flag_checker
//
// PURPOSE
// - Consumer/checker at the output end of the mutex sign classifier: takes the
//   same sample stream driven into the classifier plus its positive_flag/negative_flag
//   outputs, re-aligns the sample to the classifier latency and checks every result.
// - Verifies flag mutual exclusion and flag correctness, and keeps positive/negative/zero
//   tallies. Latches a sticky fault for fault-injection campaigns.
//
// PARAMETERS
// - DATA_W  16  sample width; two's complement
// - LAT     1   classifier latency in clk cycles (1..4)
// - CNT_W   16  width of each tally counter
//
// PORTS
// - clk           in   1       single clock, rising edge
// - rst_n         in   1       asynchronous, active-low reset
// - start         in   1       pulse: arm checking (IDLE only)
// - clear         in   1       pulse: return to IDLE, zero counters, drop fault
// - in_valid      in   1       sample on `sample` is live this cycle
// - sample        in   DATA_W  value driven to the classifier `in` this cycle
// - positive_flag in   1       classifier output
// - negative_flag in   1       classifier output
// - busy          out  1       state == CHECK
// - fault         out  1       sticky; state == FAULT
// - fault_code    out  2       00 none, 01 both flags high, 10 flag mismatch, 11 both
// - pos_cnt       out  CNT_W   checked samples classified positive
// - neg_cnt       out  CNT_W   checked samples classified negative
// - zero_cnt      out  CNT_W   checked samples equal to zero
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; delay line valid bits 0; every output 0.
// - Delay line: LAT stages of {in_valid, sample}. Stage LAT aligns with the flags.
//   Flushed (valid bits 0) on the edge that takes IDLE->CHECK.
// - Expected flags from aligned sample d: exp_neg = d[DATA_W-1];
//   exp_pos = ~d[DATA_W-1] & |d; zero gives 00. 0x8000 (DATA_W=16) is negative.
// - Check event: state CHECK and aligned valid = 1. Slots with aligned valid = 0
//   are ignored (flags not examined).
// - On a check event, at the same edge:
//   - exclusivity error: positive_flag & negative_flag.
//   - mismatch error: {positive_flag,negative_flag} != {exp_pos,exp_neg}.
//   - No error: increment the matching counter. Counters saturate at all-ones and
//     do not wrap.
//   - Any error: no counter increments; fault_code <= {mismatch,excl}; state -> FAULT.
//     fault is high from the cycle after the offending flags.
// - FSM:
//   - IDLE -> CHECK on start.
//   - CHECK -> FAULT on any error.
//   - FAULT holds until clear.
//   - clear in any state -> IDLE next edge; counters, fault_code and delay line zeroed.
//   - start outside IDLE is ignored. If start and clear are asserted in the same cycle,
//     clear wins.
// - Counters and fault_code hold their values in IDLE (after a prior run) and in FAULT.
// - Reset mid-run aborts immediately; the first check event after start+LAT cycles
//   uses the first sample presented on or after the start cycle.
//
// CONFIGURATION
// - SIGN_CHK_CAPTURE_EN defined: adds outputs cap_sample[DATA_W-1:0] and cap_flags[1:0]
//   ({positive_flag,negative_flag}).
//   - Loaded only on the CHECK->FAULT edge with the offending aligned sample and flags.
//   - Zero on reset and on clear.
// - Not defined: those ports and registers do not exist; all other behaviour is identical.
//
// TESTING
// - LAT=1: start, then feed 10, 0xFFFB, 0, 12345, 0xCFC7, 32767, 0x8000 with correct
//   flags one cycle later -> pos_cnt=3, neg_cnt=3, zero_cnt=1, fault=0, busy=1.
// - Sample 10, force flags 11 on the aligned cycle -> fault=1 next cycle, fault_code=11
//   (also mismatch), counters frozen; with SIGN_CHK_CAPTURE_EN, cap_sample=10, cap_flags=11.
// - Sample 0xFFFB, flags 10 -> fault_code=10. Then clear -> IDLE, all outputs 0,
//   busy=0.
// - CNT_W=2: five positive samples -> pos_cnt saturates at 3 without fault.
// - in_valid=0 slots with garbage flags 11 -> no fault, no count change.
//   start and clear in the same cycle -> stays IDLE.
// - Assert rst_n=0 mid-CHECK -> all outputs 0 asynchronously; a fresh start resumes
//   checking after LAT cycles.

Source files
------------

// File: rtl/sign_flag_checker.sv
// Checker for the mutex sign classifier: re-aligns the sample stream to the classifier
// latency, verifies its flags, tallies results. Define SIGN_CHK_CAPTURE_EN to capture the offending result.
module sign_flag_checker #(
  parameter int DATA_W = 16,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              positive_flag,
  input  logic              negative_flag,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [CNT_W-1:0]  pos_cnt,
  output logic [CNT_W-1:0]  neg_cnt,
  output logic [CNT_W-1:0]  zero_cnt
`ifdef SIGN_CHK_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] cap_sample,
  output logic [1:0]        cap_flags
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                        state_q;
  logic                          busy_q;
  logic                          fault_q;
  logic [1:0]                    code_q;
  logic [CNT_W-1:0]              pos_q, neg_q, zero_q;
  logic [LAT-1:0]                vld_q;
  logic [LAT-1:0][DATA_W-1:0]    smp_q;

  logic              aligned_vld;
  logic [DATA_W-1:0] aligned_smp;
  logic              exp_pos, exp_neg;
  logic              check_evt;
  logic              excl_err, mism_err, any_err;
  logic              arm;

  assign aligned_vld = vld_q[LAT-1];
  assign aligned_smp = smp_q[LAT-1];
  assign exp_neg     = aligned_smp[DATA_W-1];
  assign exp_pos     = ~aligned_smp[DATA_W-1] & (|aligned_smp);
  assign check_evt   = (state_q == ST_CHECK) && aligned_vld;
  assign excl_err    = positive_flag & negative_flag;
  assign mism_err    = {positive_flag, negative_flag} != {exp_pos, exp_neg};
  assign any_err     = excl_err | mism_err;
  assign arm         = (state_q == ST_IDLE) && start;

  // Control FSM; clear takes priority over every transition, including start.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else if (clear) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CHECK;
            busy_q  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (check_evt && any_err) begin
            state_q <= ST_FAULT;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= {mism_err, excl_err};
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  // Tallies saturate at all-ones so a long run never reports a wrapped small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      neg_q  <= '0;
      zero_q <= '0;
    end else if (clear) begin
      pos_q  <= '0;
      neg_q  <= '0;
      zero_q <= '0;
    end else if (check_evt && !any_err) begin
      if (exp_pos) begin
        if (!(&pos_q)) pos_q <= pos_q + CNT_ONE;
      end else if (exp_neg) begin
        if (!(&neg_q)) neg_q <= neg_q + CNT_ONE;
      end else begin
        if (!(&zero_q)) zero_q <= zero_q + CNT_ONE;
      end
    end
  end

  // Delay line: stage 0 takes the live input, stage LAT-1 lines up with the flags.
  // On arming, older stages are invalidated but the start-cycle sample is kept.
  // NOTE: the delay line is a handful of flops, so it is fully reset rather than left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      smp_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
      smp_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      smp_q[0] <= sample;
      for (int i = LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        smp_q[i] <= smp_q[i-1];
      end
      if (arm) begin
        for (int i = 1; i < LAT; i++) vld_q[i] <= 1'b0;
      end
    end
  end

`ifdef SIGN_CHK_CAPTURE_EN
  logic [DATA_W-1:0] cap_smp_q;
  logic [1:0]        cap_flg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_smp_q <= '0;
      cap_flg_q <= 2'b00;
    end else if (clear) begin
      cap_smp_q <= '0;
      cap_flg_q <= 2'b00;
    end else if (check_evt && any_err) begin
      cap_smp_q <= aligned_smp;
      cap_flg_q <= {positive_flag, negative_flag};
    end
  end

  assign cap_sample = cap_smp_q;
  assign cap_flags  = cap_flg_q;
`endif

  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign pos_cnt    = pos_q;
  assign neg_cnt    = neg_q;
  assign zero_cnt   = zero_q;

endmodule

// File: tb/tb_sign_flag_checker.sv
// Self-checking bench for sign_flag_checker: directed spec scenarios plus randomized
// traffic, checked every cycle against a behavioural model (main and 2-bit-counter instances).
module tb_sign_flag_checker;

  localparam int DATA_W = 16;
  localparam int LAT    = 1;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, clear, in_valid;
  logic [DATA_W-1:0] sample;
  logic              positive_flag, negative_flag;

  logic              busy_a, fault_a, busy_b, fault_b;
  logic [1:0]        code_a, code_b;
  logic [CNT_W-1:0]  pos_a, neg_a, zero_a;
  logic [SAT_W-1:0]  pos_b, neg_b, zero_b;
`ifdef SIGN_CHK_CAPTURE_EN
  logic [DATA_W-1:0] cap_s_a, cap_s_b;
  logic [1:0]        cap_f_a, cap_f_b;
`endif

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sign_flag_checker #(.DATA_W(DATA_W), .LAT(LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid),
    .sample(sample), .positive_flag(positive_flag), .negative_flag(negative_flag),
    .busy(busy_a), .fault(fault_a), .fault_code(code_a),
    .pos_cnt(pos_a), .neg_cnt(neg_a), .zero_cnt(zero_a)
`ifdef SIGN_CHK_CAPTURE_EN
    , .cap_sample(cap_s_a), .cap_flags(cap_f_a)
`endif
  );

  sign_flag_checker #(.DATA_W(DATA_W), .LAT(LAT), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid),
    .sample(sample), .positive_flag(positive_flag), .negative_flag(negative_flag),
    .busy(busy_b), .fault(fault_b), .fault_code(code_b),
    .pos_cnt(pos_b), .neg_cnt(neg_b), .zero_cnt(zero_b)
`ifdef SIGN_CHK_CAPTURE_EN
    , .cap_sample(cap_s_b), .cap_flags(cap_f_b)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [15:0] s;
  } slot_t;

  slot_t       pipe[$];
  bit          m_busy, m_fault;
  bit [1:0]    m_code;
  int          m_pos, m_neg, m_zero;
  logic [15:0] m_cap_s;
  bit [1:0]    m_cap_f;

  bit          prev_v;
  logic [15:0] prev_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_fault = 0; m_code = 2'b00;
    m_pos = 0; m_neg = 0; m_zero = 0;
    m_cap_s = '0; m_cap_f = 2'b00;
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back('{v: 1'b0, s: 16'h0});
  endtask

  // Applies the rules for one clock edge, using the inputs presented in the cycle before it.
  task automatic model_edge();
    slot_t al;
    bit ep, en, ex, mm;
    al = pipe[LAT-1];
    if (clear) begin
      model_reset();
    end else begin
      if (!m_busy && !m_fault && start) begin
        m_busy = 1;
        for (int i = 0; i < LAT; i++) pipe[i].v = 1'b0;
      end else if (m_busy && al.v) begin
        ep = $signed(al.s) > 0;
        en = $signed(al.s) < 0;
        ex = positive_flag && negative_flag;
        mm = (positive_flag != ep) || (negative_flag != en);
        if (ex || mm) begin
          m_busy = 0; m_fault = 1; m_code = {mm, ex};
          m_cap_s = al.s; m_cap_f = {positive_flag, negative_flag};
        end else if (ep) m_pos++;
        else if (en) m_neg++;
        else m_zero++;
      end
      pipe.push_front('{v: in_valid, s: sample});
      void'(pipe.pop_back());
    end
  endtask

  // One cycle of stimulus; flags normally carry the correct result for the previous sample.
  task automatic step(input bit st, input bit clr, input bit v, input logic [15:0] s,
                      input bit ovr = 1'b0, input logic [1:0] fl = 2'b00);
    logic [1:0] f;
    if (ovr) f = fl;
    else if (prev_v) f = {$signed(prev_s) > 0, $signed(prev_s) < 0};
    else f = 2'($urandom_range(0, 3));
    start = st; clear = clr; in_valid = v; sample = s;
    {positive_flag, negative_flag} = f;
    @(posedge clk);
    model_edge();
    prev_v = v; prev_s = s;
    #1;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        check("busy",      32'(busy_a),  32'(m_busy));
        check("fault",     32'(fault_a), 32'(m_fault));
        check("fault_code",32'(code_a),  32'(m_code));
        check("pos_cnt",   32'(pos_a),   sat(m_pos, CNT_W));
        check("neg_cnt",   32'(neg_a),   sat(m_neg, CNT_W));
        check("zero_cnt",  32'(zero_a),  sat(m_zero, CNT_W));
        check("sat_fault", 32'(fault_b), 32'(m_fault));
        check("sat_pos",   32'(pos_b),   sat(m_pos, SAT_W));
        check("sat_neg",   32'(neg_b),   sat(m_neg, SAT_W));
        check("sat_zero",  32'(zero_b),  sat(m_zero, SAT_W));
`ifdef SIGN_CHK_CAPTURE_EN
        check("cap_sample", 32'(cap_s_a), 32'(m_cap_s));
        check("cap_flags",  32'(cap_f_a), 32'(m_cap_f));
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy_a),  0);
    check({tag, "_fault"}, 32'(fault_a), 0);
    check({tag, "_code"},  32'(code_a),  0);
    check({tag, "_pos"},   32'(pos_a),   0);
    check({tag, "_neg"},   32'(neg_a),   0);
    check({tag, "_zero"},  32'(zero_a),  0);
  endtask

  initial begin
    logic [15:0] s;
    rst_n = 1'b0; start = 0; clear = 0; in_valid = 0; sample = '0;
    positive_flag = 0; negative_flag = 0;
    prev_v = 0; prev_s = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Directed: mixed stream with correct flags.
    step(1, 0, 1, 16'd10);
    step(0, 0, 1, 16'hFFFB);
    step(0, 0, 1, 16'd0);
    step(0, 0, 1, 16'd12345);
    step(0, 0, 1, 16'hCFC7);
    step(0, 0, 1, 16'd32767);
    step(0, 0, 1, 16'h8000);
    step(0, 0, 0, 16'h0);
    check("dir_pos",  32'(pos_a), 3);
    check("dir_neg",  32'(neg_a), 3);
    check("dir_zero", 32'(zero_a), 1);
    check("dir_fault",32'(fault_a), 0);
    check("dir_busy", 32'(busy_a), 1);

    // Both flags high on a positive sample.
    step(0, 0, 1, 16'd10);
    step(0, 0, 0, 16'h0, 1'b1, 2'b11);
    check("f11_fault", 32'(fault_a), 1);
    check("f11_code",  32'(code_a), 3);
    check("f11_pos",   32'(pos_a), 3);
`ifdef SIGN_CHK_CAPTURE_EN
    check("f11_cap_s", 32'(cap_s_a), 10);
    check("f11_cap_f", 32'(cap_f_a), 3);
`endif
    step(0, 0, 1, 16'd20);
    step(0, 0, 0, 16'h0);
    check("frozen_pos", 32'(pos_a), 3);
    step(0, 1, 0, 16'h0);
    check_all_zero("clear1");

    // Positive flag on a negative sample: mismatch only.
    step(1, 0, 1, 16'hFFFB);
    step(0, 0, 0, 16'h0, 1'b1, 2'b10);
    check("f10_fault", 32'(fault_a), 1);
    check("f10_code",  32'(code_a), 2);
    step(0, 1, 0, 16'h0);
    check_all_zero("clear2");

    // Saturation of the 2-bit instance.
    step(1, 0, 1, 16'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(100 + i));
    step(0, 0, 0, 16'h0);
    check("sat_main_pos", 32'(pos_a), 5);
    check("sat_b_pos",    32'(pos_b), 3);
    check("sat_b_fault",  32'(fault_b), 0);

    // Invalid slots carrying garbage flags.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'hDEAD, 1'b1, 2'b11);
    check("gap_fault", 32'(fault_a), 0);
    check("gap_pos",   32'(pos_a), 5);

    // start and clear together: clear wins.
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    check("stclr_busy", 32'(busy_a), 0);

    // Asynchronous reset mid-check, then a fresh run.
    step(1, 0, 1, 16'd7);
    step(0, 0, 1, 16'hFFFD);
    #2;
    rst_n = 1'b0;
    model_reset();
    prev_v = 0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 1, 16'd5);
    step(0, 0, 0, 16'h0);
    check("rerun_pos",  32'(pos_a), 1);
    check("rerun_busy", 32'(busy_a), 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: s = 16'h0000;
        1: s = 16'h8000;
        2: s = 16'h7FFF;
        3: s = 16'hFFFF;
        4: s = 16'h0001;
        default: s = 16'($urandom);
      endcase
      step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 70, s,
           $urandom_range(0, 99) < 3, 2'($urandom_range(0, 3)));
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
